// File: rtl/memory_pkg.sv
// Shared memory-system constants used to size address ports across the core.
package memory_pkg;
    localparam int MEM_ADDR_WIDTH = 16;
endpackage

// File: rtl/core_boot_ctrl.sv
// core_boot_ctrl: sequences a core run (reset hold, clock enable, first fetch, run, drain, stop).
// Define CORE_BOOT_CTRL_WATCHDOG_EN to build the retire-driven watchdog and its timeout flag.
module core_boot_ctrl #(
    parameter int ADDR_W            = memory_pkg::MEM_ADDR_WIDTH,
    parameter int RESET_HOLD_CYCLES = 10,
    parameter int DRAIN_CYCLES      = 4,
    parameter int WATCHDOG_TIM      = 50
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic              halt_req,
    input  logic              retire,
    input  logic              abort,
    output logic              core_rstn,
    output logic              cg_clk_en,
    output logic              first_fetch_trigger,
    output logic [ADDR_W-1:0] first_fetch_addr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST_HOLD = 3'd1,
        CLK_ON   = 3'd2,
        FETCH    = 3'd3,
        RUN      = 3'd4,
        DRAIN    = 3'd5,
        STOP     = 3'd6
    } state_t;

    // One down-counter is shared by the reset-hold and drain phases.
    localparam int PH_MAX = (RESET_HOLD_CYCLES > DRAIN_CYCLES) ? RESET_HOLD_CYCLES : DRAIN_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    state_t            state_q;
    state_t            state_d;
    logic [PH_W-1:0]   ph_cnt;
    logic              wd_expire;
    logic              core_rstn_d;
    logic              cg_clk_en_d;
    logic              trigger_d;
    logic              busy_d;
    logic              done_d;
    logic              timeout_d;
    logic [ADDR_W-1:0] addr_d;

`ifdef CORE_BOOT_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_TIM);

    logic [WD_W-1:0] wd_cnt;

    // A retire on the expiry cycle wins: the count restarts instead of timing out.
    assign wd_expire = (state_q == RUN) && !retire && (wd_cnt == WD_W'(WATCHDOG_TIM - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
        end else if ((state_q != RUN) || retire) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    logic wd_unused;

    assign wd_unused = retire & (WATCHDOG_TIM > 1);
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph_cnt <= '0;
        end else if ((state_d == RST_HOLD) && (state_q != RST_HOLD)) begin
            ph_cnt <= PH_W'(RESET_HOLD_CYCLES - 1);
        end else if ((state_d == DRAIN) && (state_q != DRAIN)) begin
            ph_cnt <= PH_W'(DRAIN_CYCLES - 1);
        end else if (ph_cnt != '0) begin
            ph_cnt <= ph_cnt - PH_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        timeout_d = timeout;
        addr_d    = first_fetch_addr;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RST_HOLD;
                    addr_d    = boot_addr;
                    timeout_d = 1'b0;
                end
            end
            RST_HOLD: begin
                if (ph_cnt == '0) begin
                    state_d = CLK_ON;
                end
            end
            CLK_ON: state_d = FETCH;
            FETCH:  state_d = RUN;
            RUN: begin
                if (halt_req) begin
                    state_d = DRAIN;
                end else if (wd_expire) begin
                    state_d   = STOP;
                    timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                if (ph_cnt == '0) begin
                    state_d = STOP;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything in an active run and leaves the timeout flag alone.
        if (abort && (state_q inside {RST_HOLD, CLK_ON, FETCH, RUN, DRAIN})) begin
            state_d   = STOP;
            timeout_d = timeout;
        end

        // Outputs are decoded from the next state so they register in step with it.
        core_rstn_d = core_rstn;
        if (state_d == RST_HOLD) begin
            core_rstn_d = 1'b0;
        end else if (state_d == CLK_ON) begin
            core_rstn_d = 1'b1;
        end
        cg_clk_en_d = state_d inside {CLK_ON, FETCH, RUN, DRAIN};
        trigger_d   = (state_d == FETCH);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == STOP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q             <= IDLE;
            core_rstn           <= 1'b0;
            cg_clk_en           <= 1'b0;
            first_fetch_trigger <= 1'b0;
            first_fetch_addr    <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            timeout             <= 1'b0;
        end else begin
            state_q             <= state_d;
            core_rstn           <= core_rstn_d;
            cg_clk_en           <= cg_clk_en_d;
            first_fetch_trigger <= trigger_d;
            first_fetch_addr    <= addr_d;
            busy                <= busy_d;
            done                <= done_d;
            timeout             <= timeout_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Self-checking bench for core_boot_ctrl: scenario tasks compared against a timestamp-based run model.
// Works in both builds; watchdog expectations follow CORE_BOOT_CTRL_WATCHDOG_EN.
module tb_core_boot_ctrl;

    localparam int ADDR_W = 16;
    localparam int RHC    = 10;
    localparam int DC     = 4;
    localparam int WT     = 50;
    localparam int MAXE   = 200;

    localparam int S_IDLE = 0, S_RST_HOLD = 1, S_CLK_ON = 2, S_FETCH = 3;
    localparam int S_RUN  = 4, S_DRAIN = 5, S_STOP = 6;

`ifdef CORE_BOOT_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic              clk;
    logic              rstn;
    logic              start;
    logic [ADDR_W-1:0] boot_addr;
    logic              halt_req;
    logic              retire;
    logic              abort;
    logic              core_rstn;
    logic              cg_clk_en;
    logic              first_fetch_trigger;
    logic [ADDR_W-1:0] first_fetch_addr;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [2:0]        state;

    core_boot_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .start               (start),
        .boot_addr           (boot_addr),
        .halt_req            (halt_req),
        .retire              (retire),
        .abort               (abort),
        .core_rstn           (core_rstn),
        .cg_clk_en           (cg_clk_en),
        .first_fetch_trigger (first_fetch_trigger),
        .first_fetch_addr    (first_fetch_addr),
        .busy                (busy),
        .done                (done),
        .timeout             (timeout),
        .state               (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Stimulus per bench edge: a value driven after edge e is sampled by the DUT at edge e+1.
    bit          st_s [0:MAXE];
    bit          ha_s [0:MAXE];
    bit          re_s [0:MAXE];
    bit          ab_s [0:MAXE];
    logic [8:0]  exp_v [0:MAXE];
    logic [8:0]  obs_v [0:MAXE];
    logic [15:0] obs_addr [0:MAXE];
    int          run_len;
    bit          m_rstn;
    bit          m_tmo;
    logic [15:0] cur_addr;

    function automatic logic [8:0] pack(input int st, input bit r, input bit t);
        logic cg;
        cg = (st >= S_CLK_ON) && (st <= S_DRAIN);
        return {st[2:0], (st != S_IDLE), r, cg, (st == S_FETCH), (st == S_STOP), t};
    endfunction

    task automatic clear_stim();
        for (int e = 0; e <= MAXE; e++) begin
            st_s[e] = 1'b0;
            ha_s[e] = 1'b0;
            re_s[e] = 1'b0;
            ab_s[e] = 1'b0;
        end
        st_s[0] = 1'b1;
    endtask

    // Run model: phases by elapsed time since entry, watchdog as time since last sign of life.
    task automatic build_model();
        int s, n, hold_b, drain_b, alive;
        bit r, t, t_prev;
        s = S_IDLE; r = m_rstn; t = m_tmo;
        hold_b = 0; drain_b = 0; alive = 0;
        run_len = MAXE;
        exp_v[0] = pack(s, r, t);
        for (int e = 1; e <= MAXE; e++) begin
            n = s;
            t_prev = t;
            case (s)
                S_IDLE:     if (st_s[e-1]) begin n = S_RST_HOLD; hold_b = e; t = 1'b0; end
                S_RST_HOLD: if (e - hold_b >= RHC) n = S_CLK_ON;
                S_CLK_ON:   n = S_FETCH;
                S_FETCH:    begin n = S_RUN; alive = e; end
                S_RUN: begin
                    if (ha_s[e-1]) begin
                        n = S_DRAIN; drain_b = e;
                    end else if (re_s[e-1]) begin
                        alive = e;
                    end else if (WD_EN && (e - alive >= WT)) begin
                        n = S_STOP; t = 1'b1;
                    end
                end
                S_DRAIN:    if (e - drain_b >= DC) n = S_STOP;
                default:    n = S_IDLE;
            endcase
            if (ab_s[e-1] && (s != S_IDLE) && (s != S_STOP)) begin
                n = S_STOP; t = t_prev;
            end
            if (n == S_RST_HOLD) r = 1'b0;
            if (n == S_CLK_ON) r = 1'b1;
            exp_v[e] = pack(n, r, t);
            if ((n == S_IDLE) && (s == S_STOP)) begin
                run_len = e;
                break;
            end
            s = n;
        end
        m_rstn = r;
        m_tmo  = t;
    endtask

    task automatic drive_run(input int reset_at);
        for (int e = 0; e <= run_len; e++) begin
            @(posedge clk);
            #1;
            obs_v[e]    = {state, busy, core_rstn, cg_clk_en, first_fetch_trigger, done, timeout};
            obs_addr[e] = first_fetch_addr;
            if (e == reset_at) begin
                rstn = 1'b0;
                start = 1'b0; halt_req = 1'b0; retire = 1'b0; abort = 1'b0;
                return;
            end
            start     = st_s[e];
            halt_req  = ha_s[e];
            retire    = re_s[e];
            abort     = ab_s[e];
            boot_addr = (e == 0) ? cur_addr : 16'($urandom);
        end
        start = 1'b0; halt_req = 1'b0; retire = 1'b0; abort = 1'b0;
    endtask

    task automatic set_nominal_stim(input logic [15:0] a);
        clear_stim();
        cur_addr = a;
        for (int e = 0; e <= MAXE; e++) re_s[e] = 1'b1;
        ha_s[30] = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; halt_req = 1'b0; retire = 1'b1; abort = 1'b0;
        boot_addr = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({state, busy, core_rstn, cg_clk_en, first_fetch_trigger, done, timeout} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b expected=%b", {state, busy, core_rstn, cg_clk_en, first_fetch_trigger, done, timeout}, 9'b0);
        end
        checks++;
        if (first_fetch_addr !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_addr got=%h expected=0000", first_fetch_addr);
        end
        start = 1'b0; retire = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_idle state=%0d busy=%b expected state=0 busy=0", state, busy);
        end
        m_rstn = 1'b0;
        m_tmo  = 1'b0;
    endtask

    task automatic test_nominal();
        set_nominal_stim(16'h0040);
        build_model();
        drive_run(-1);
        for (int e = 0; e <= run_len; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++;
                $display("[TB] FAIL nominal_timeline e=%0d got=%b expected=%b", e, obs_v[e], exp_v[e]);
            end
        end
        checks++;
        if (obs_v[10][4] !== 1'b0 || obs_v[11][4] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nominal_core_rstn_edge e10=%b e11=%b expected 0 then 1", obs_v[10][4], obs_v[11][4]);
        end
        checks++;
        if (obs_v[12][2] !== 1'b1 || obs_addr[12] !== 16'h0040) begin
            errors++;
            $display("[TB] FAIL nominal_fetch trigger=%b addr=%h expected 1 and 0040", obs_v[12][2], obs_addr[12]);
        end
        checks++;
        if (obs_v[35][8:6] !== 3'd6 || obs_v[35][1] !== 1'b1 || obs_v[36][8:6] !== 3'd0 || obs_v[36][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nominal_stop e35=%b e36=%b expected STOP+done then IDLE no timeout", obs_v[35], obs_v[36]);
        end
    endtask

    task automatic test_watchdog();
        clear_stim();
        cur_addr = 16'h1234;
        if (!WD_EN) ha_s[100] = 1'b1;
        build_model();
        drive_run(-1);
        for (int e = 0; e <= run_len; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++;
                $display("[TB] FAIL watchdog_timeline e=%0d got=%b expected=%b", e, obs_v[e], exp_v[e]);
            end
        end
        checks++;
        if (obs_v[13][8:6] !== 3'd4) begin
            errors++;
            $display("[TB] FAIL watchdog_run_entry state=%0d expected=4", obs_v[13][8:6]);
        end
`ifdef CORE_BOOT_CTRL_WATCHDOG_EN
        checks++;
        if (obs_v[62][8:6] !== 3'd4 || obs_v[63][8:6] !== 3'd6 || obs_v[63][0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL watchdog_expiry e62=%b e63=%b expected RUN then STOP with timeout", obs_v[62], obs_v[63]);
        end
        checks++;
        if (obs_v[64][8:6] !== 3'd0 || obs_v[64][0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL watchdog_sticky got=%b expected IDLE with timeout=1", obs_v[64]);
        end
`else
        checks++;
        if (obs_v[63][8:6] !== 3'd4 || obs_v[63][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL watchdog_disabled got=%b expected RUN without timeout", obs_v[63]);
        end
`endif
    endtask

    task automatic test_retire_collision();
        clear_stim();
        cur_addr = 16'h0ABC;
        re_s[62] = 1'b1;
        if (!WD_EN) ha_s[130] = 1'b1;
        build_model();
        drive_run(-1);
        for (int e = 0; e <= run_len; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++;
                $display("[TB] FAIL collision_timeline e=%0d got=%b expected=%b", e, obs_v[e], exp_v[e]);
            end
        end
        checks++;
        if (obs_v[1][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collision_start_clears_timeout got=%b expected=0", obs_v[1][0]);
        end
        checks++;
        if (obs_v[63][8:6] !== 3'd4 || obs_v[63][0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL collision_no_timeout got=%b expected RUN timeout=0", obs_v[63]);
        end
`ifdef CORE_BOOT_CTRL_WATCHDOG_EN
        checks++;
        if (obs_v[112][8:6] !== 3'd4 || obs_v[113][8:6] !== 3'd6 || obs_v[113][0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision_restart e112=%b e113=%b expected RUN then STOP with timeout", obs_v[112], obs_v[113]);
        end
`endif
    endtask

    task automatic test_abort_ignored_start();
        clear_stim();
        cur_addr = 16'h5555;
        st_s[4] = 1'b1;
        ab_s[5] = 1'b1;
        build_model();
        drive_run(-1);
        for (int e = 0; e <= run_len; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++;
                $display("[TB] FAIL abort_timeline e=%0d got=%b expected=%b", e, obs_v[e], exp_v[e]);
            end
            checks++;
            if (obs_v[e][3] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_cg_never e=%0d got=%b expected=0", e, obs_v[e][3]);
            end
        end
        checks++;
        if (obs_v[6][8:6] !== 3'd6 || obs_v[6][1] !== 1'b1 || obs_v[5][8:6] !== 3'd1) begin
            errors++;
            $display("[TB] FAIL abort_stop e5=%b e6=%b expected RST_HOLD then STOP with done", obs_v[5], obs_v[6]);
        end
    endtask

    task automatic test_reset_mid_drain();
        set_nominal_stim(16'h00F0);
        build_model();
        drive_run(33);
        for (int e = 0; e <= 33; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++;
                $display("[TB] FAIL middrain_timeline e=%0d got=%b expected=%b", e, obs_v[e], exp_v[e]);
            end
        end
        #1;
        checks++;
        if ({state, busy, core_rstn, cg_clk_en, first_fetch_trigger, done, timeout} !== 9'b0 || first_fetch_addr !== 16'h0) begin
            errors++;
            $display("[TB] FAIL middrain_async_reset got=%b addr=%h expected all zero", {state, busy, core_rstn, cg_clk_en, first_fetch_trigger, done, timeout}, first_fetch_addr);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_rstn = 1'b0;
        m_tmo  = 1'b0;
        set_nominal_stim(16'h0040);
        build_model();
        drive_run(-1);
        for (int e = 0; e <= run_len; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++;
                $display("[TB] FAIL middrain_rerun e=%0d got=%b expected=%b", e, obs_v[e], exp_v[e]);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        for (int r = 0; r < 6; r++) begin
            int cut;
            clear_stim();
            cur_addr = 16'($urandom);
            cut = $urandom_range(20, 120);
            for (int e = 0; e <= MAXE; e++) re_s[e] = (e < cut) && ($urandom_range(0, 9) < 8);
            if (!WD_EN || $urandom_range(0, 2) != 0) ha_s[$urandom_range(13, 95)] = 1'b1;
            if ($urandom_range(0, 3) == 0) ab_s[$urandom_range(1, 60)] = 1'b1;
            build_model();
            if (run_len > 2 && $urandom_range(0, 1) == 1) st_s[$urandom_range(1, run_len - 1)] = 1'b1;
            drive_run(-1);
            for (int e = 0; e <= run_len; e++) begin
                checks++;
                if (obs_v[e] !== exp_v[e]) begin
                    errors++;
                    $display("[TB] FAIL random%0d_timeline e=%0d got=%b expected=%b", r, e, obs_v[e], exp_v[e]);
                end
            end
            checks++;
            if (obs_addr[run_len] !== cur_addr) begin
                errors++;
                $display("[TB] FAIL random%0d_addr got=%h expected=%h", r, obs_addr[run_len], cur_addr);
            end
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL sim_time_limit reached without finishing");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        m_rstn = 1'b0;
        m_tmo  = 1'b0;
        cur_addr = 16'h0;
        test_reset();
        test_nominal();
        test_watchdog();
        test_retire_collision();
        test_abort_ignored_start();
        test_reset_mid_drain();
        test_random_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
